// File: rtl/idex_hazard_if.sv
// Decode/Execute hazard bundle: decode fields and M/W destinations in, registered
// Execute controls plus forward/stall/flush selects out.
interface idex_hazard_if;
  logic [2:0] alu_src_b_d;
  logic       reg_write_d;
  logic [1:0] result_src_d;
  logic [4:0] rs1_d;
  logic [4:0] rs2_d;
  logic [4:0] rd_d;
  logic [4:0] rd_m;
  logic [4:0] rd_w;
  logic       reg_write_m;
  logic       reg_write_w;
  logic       pc_src_e;

  logic [2:0] alu_src_b_e;
  logic       reg_write_e;
  logic [1:0] result_src_e;
  logic [4:0] rs1_e;
  logic [4:0] rs2_e;
  logic [4:0] rd_e;
  logic [1:0] forward_a_e;
  logic [1:0] forward_b_e;
  logic [1:0] forward_wd_e;
  logic       stall_f;
  logic       stall_d;
  logic       flush_d;
  logic       flush_e;

  modport master (
    output alu_src_b_d, reg_write_d, result_src_d, rs1_d, rs2_d, rd_d,
    output rd_m, rd_w, reg_write_m, reg_write_w, pc_src_e,
    input  alu_src_b_e, reg_write_e, result_src_e, rs1_e, rs2_e, rd_e,
    input  forward_a_e, forward_b_e, forward_wd_e,
    input  stall_f, stall_d, flush_d, flush_e
  );

  modport slave (
    input  alu_src_b_d, reg_write_d, result_src_d, rs1_d, rs2_d, rd_d,
    input  rd_m, rd_w, reg_write_m, reg_write_w, pc_src_e,
    output alu_src_b_e, reg_write_e, result_src_e, rs1_e, rs2_e, rd_e,
    output forward_a_e, forward_b_e, forward_wd_e,
    output stall_f, stall_d, flush_d, flush_e
  );
endinterface

// File: rtl/idex_hazard_ctrl.sv
// ID/EX pipeline register with load-use stall, branch flush and operand forwarding.
// Optional stall/flush statistics counters are built when IDEX_HAZARD_STATS_EN is defined.
module idex_hazard_ctrl (
  input  logic          clk,
  input  logic          reset,
  idex_hazard_if.slave  hz
`ifdef IDEX_HAZARD_STATS_EN
  ,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   flush_cnt
`endif
);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_t;

  state_t     state_reg;
  logic [2:0] alu_src_b_e_reg;
  logic       reg_write_e_reg;
  logic [1:0] result_src_e_reg;
  logic [4:0] rs1_e_reg;
  logic [4:0] rs2_e_reg;
  logic [4:0] rd_e_reg;

  logic       lu;
  logic       stall;
  logic       flush_e;
  logic [4:0] src_e [2];
  logic [1:0] fwd_sel [2];

  // Load in Execute whose destination feeds the instruction in Decode
  assign lu = (result_src_e_reg == 2'b01) && (rd_e_reg != 5'd0) &&
              ((rd_e_reg == hz.rs1_d) || (rd_e_reg == hz.rs2_d));

  // A taken branch discards Decode anyway, so it overrides the stall
  assign stall   = lu && !hz.pc_src_e;
  assign flush_e = hz.pc_src_e || lu;

  assign hz.stall_f = stall;
  assign hz.stall_d = stall;
  assign hz.flush_d = hz.pc_src_e;
  assign hz.flush_e = flush_e;

  always_ff @(posedge clk) begin
    if (reset || flush_e) begin
      alu_src_b_e_reg  <= 3'b000;
      reg_write_e_reg  <= 1'b0;
      result_src_e_reg <= 2'b00;
      rs1_e_reg        <= 5'd0;
      rs2_e_reg        <= 5'd0;
      rd_e_reg         <= 5'd0;
    end else begin
      alu_src_b_e_reg  <= hz.alu_src_b_d;
      reg_write_e_reg  <= hz.reg_write_d;
      result_src_e_reg <= hz.result_src_d;
      rs1_e_reg        <= hz.rs1_d;
      rs2_e_reg        <= hz.rs2_d;
      rd_e_reg         <= hz.rd_d;
    end
  end

  // BUBBLE marks the cycle Execute holds the inserted no-op; lu cannot recur there
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= RUN;
    end else if (hz.pc_src_e) begin
      state_reg <= RUN;
    end else begin
      case (state_reg)
        RUN:     state_reg <= lu ? BUBBLE : RUN;
        BUBBLE:  state_reg <= RUN;
        default: state_reg <= RUN;
      endcase
    end
  end

  assign hz.alu_src_b_e  = alu_src_b_e_reg;
  assign hz.reg_write_e  = reg_write_e_reg;
  assign hz.result_src_e = result_src_e_reg;
  assign hz.rs1_e        = rs1_e_reg;
  assign hz.rs2_e        = rs2_e_reg;
  assign hz.rd_e         = rd_e_reg;

  assign src_e[0] = rs1_e_reg;
  assign src_e[1] = rs2_e_reg;

  // One forwarding unit per Execute source; Memory stage wins over Writeback
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      always_comb begin
        fwd_sel[gi] = 2'b00;
        if (hz.reg_write_m && (hz.rd_m != 5'd0) && (hz.rd_m == src_e[gi])) begin
          fwd_sel[gi] = 2'b10;
        end else if (hz.reg_write_w && (hz.rd_w != 5'd0) && (hz.rd_w == src_e[gi])) begin
          fwd_sel[gi] = 2'b01;
        end
      end
    end
  endgenerate

  assign hz.forward_a_e  = fwd_sel[0];
  assign hz.forward_wd_e = fwd_sel[1];
  assign hz.forward_b_e  = (alu_src_b_e_reg == 3'b000) ? fwd_sel[1] : 2'b00;

`ifdef IDEX_HAZARD_STATS_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] flush_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= 32'd0;
      flush_cnt_reg <= 32'd0;
    end else begin
      if (stall) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
      if (hz.pc_src_e) begin
        flush_cnt_reg <= flush_cnt_reg + 32'd1;
      end
    end
  end

  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// Directed bench for idex_hazard_ctrl: reset, load-use stall, forwarding priority,
// SrcB masking, x0, branch-over-stall and reset during a bubble.
module tb_idex_hazard_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  idex_hazard_if hz ();

`ifdef IDEX_HAZARD_STATS_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  idex_hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
`ifdef IDEX_HAZARD_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic drive_d(input logic [2:0] asb, input logic rw, input logic [1:0] rs,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
    hz.alu_src_b_d  = asb;
    hz.reg_write_d  = rw;
    hz.result_src_d = rs;
    hz.rs1_d        = r1;
    hz.rs2_d        = r2;
    hz.rd_d         = rd;
  endtask

  task automatic drive_mw(input logic wm, input logic [4:0] rm, input logic ww, input logic [4:0] rw);
    hz.reg_write_m = wm;
    hz.rd_m        = rm;
    hz.reg_write_w = ww;
    hz.rd_w        = rw;
  endtask

  // Advance one rising edge and settle just after the following falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    hz.pc_src_e = 1'b0;
    drive_d(3'b110, 1'b1, 2'b01, 5'd9, 5'd9, 5'd9);
    drive_mw(1'b0, 5'd0, 1'b0, 5'd0);
    step();
    step();

    // Reset overrides capture of non-zero decode values
    check_val("rst_alu_src_b_e", 32'(hz.alu_src_b_e), 32'd0);
    check_val("rst_reg_write_e", 32'(hz.reg_write_e), 32'd0);
    check_val("rst_rd_e", 32'(hz.rd_e), 32'd0);
    reset = 1'b0;
    drive_d(3'b000, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0);
    #1;
    check_val("rst_stall_d", 32'(hz.stall_d), 32'd0);
    check_val("rst_flush_e", 32'(hz.flush_e), 32'd0);
    check_val("rst_fwd_a", 32'(hz.forward_a_e), 32'd0);
    check_val("rst_fwd_wd", 32'(hz.forward_wd_e), 32'd0);

    // Load-use: lw x5 in Execute, consumer reads x5
    drive_d(3'b010, 1'b1, 2'b01, 5'd1, 5'd2, 5'd5);
    step();
    check_val("lw_rd_e", 32'(hz.rd_e), 32'd5);
    check_val("lw_result_src_e", 32'(hz.result_src_e), 32'd1);
    drive_d(3'b000, 1'b1, 2'b00, 5'd5, 5'd0, 5'd6);
    #1;
    check_val("lu_stall_f", 32'(hz.stall_f), 32'd1);
    check_val("lu_stall_d", 32'(hz.stall_d), 32'd1);
    check_val("lu_flush_e", 32'(hz.flush_e), 32'd1);
    check_val("lu_flush_d", 32'(hz.flush_d), 32'd0);
    step();
    check_val("bub_alu_src_b_e", 32'(hz.alu_src_b_e), 32'd0);
    check_val("bub_reg_write_e", 32'(hz.reg_write_e), 32'd0);
    check_val("bub_result_src_e", 32'(hz.result_src_e), 32'd0);
    check_val("bub_stall_d", 32'(hz.stall_d), 32'd0);
    check_val("bub_state", 32'(dut.state_reg), 32'd1);
`ifdef IDEX_HAZARD_STATS_EN
    check_val("bub_stall_cnt", stall_cnt, 32'd1);
`endif
    step();
    check_val("rel_state", 32'(dut.state_reg), 32'd0);
    check_val("rel_rs1_e", 32'(hz.rs1_e), 32'd5);
    check_val("rel_rd_e", 32'(hz.rd_e), 32'd6);
    check_val("rel_reg_write_e", 32'(hz.reg_write_e), 32'd1);

    // Forward priority and SrcB masking
    drive_d(3'b010, 1'b1, 2'b00, 5'd3, 5'd7, 5'd8);
    step();
    drive_mw(1'b1, 5'd3, 1'b1, 5'd3);
    #1;
    check_val("fwd_a_mem_prio", 32'(hz.forward_a_e), 32'd2);
    check_val("fwd_wd_nomatch", 32'(hz.forward_wd_e), 32'd0);
    drive_mw(1'b0, 5'd3, 1'b1, 5'd3);
    #1;
    check_val("fwd_a_wb", 32'(hz.forward_a_e), 32'd1);
    drive_mw(1'b0, 5'd3, 1'b0, 5'd3);
    #1;
    check_val("fwd_a_none", 32'(hz.forward_a_e), 32'd0);
    drive_mw(1'b1, 5'd7, 1'b1, 5'd3);
    #1;
    check_val("fwd_a_wb2", 32'(hz.forward_a_e), 32'd1);
    check_val("fwd_wd_mem", 32'(hz.forward_wd_e), 32'd2);
    check_val("fwd_b_masked", 32'(hz.forward_b_e), 32'd0);
    drive_d(3'b000, 1'b1, 2'b00, 5'd3, 5'd7, 5'd8);
    step();
    check_val("fwd_b_reg", 32'(hz.forward_b_e), 32'd2);
    drive_mw(1'b0, 5'd0, 1'b1, 5'd7);
    #1;
    check_val("fwd_b_wb", 32'(hz.forward_b_e), 32'd1);

    // x0 never hazards or forwards
    drive_d(3'b000, 1'b1, 2'b01, 5'd0, 5'd0, 5'd0);
    step();
    drive_mw(1'b1, 5'd0, 1'b1, 5'd0);
    #1;
    check_val("x0_stall_d", 32'(hz.stall_d), 32'd0);
    check_val("x0_flush_e", 32'(hz.flush_e), 32'd0);
    check_val("x0_fwd_a", 32'(hz.forward_a_e), 32'd0);
    drive_mw(1'b0, 5'd0, 1'b0, 5'd0);

    // Taken branch wins over load-use
    drive_d(3'b000, 1'b1, 2'b01, 5'd1, 5'd0, 5'd5);
    step();
    drive_d(3'b000, 1'b1, 2'b00, 5'd0, 5'd5, 5'd4);
    hz.pc_src_e = 1'b1;
    #1;
    check_val("br_stall_f", 32'(hz.stall_f), 32'd0);
    check_val("br_stall_d", 32'(hz.stall_d), 32'd0);
    check_val("br_flush_d", 32'(hz.flush_d), 32'd1);
    check_val("br_flush_e", 32'(hz.flush_e), 32'd1);
    step();
    hz.pc_src_e = 1'b0;
    #1;
    check_val("br_state", 32'(dut.state_reg), 32'd0);
    check_val("br_rd_e", 32'(hz.rd_e), 32'd0);
`ifdef IDEX_HAZARD_STATS_EN
    check_val("br_flush_cnt", flush_cnt, 32'd1);
    check_val("br_stall_cnt", stall_cnt, 32'd1);
`endif

    // Reset while in BUBBLE
    drive_d(3'b000, 1'b1, 2'b01, 5'd1, 5'd0, 5'd5);
    step();
    drive_d(3'b000, 1'b1, 2'b00, 5'd5, 5'd0, 5'd6);
    step();
    check_val("rb_state_bubble", 32'(dut.state_reg), 32'd1);
    reset = 1'b1;
    drive_d(3'b110, 1'b1, 2'b01, 5'd5, 5'd5, 5'd5);
    step();
    check_val("rb_alu_src_b_e", 32'(hz.alu_src_b_e), 32'd0);
    check_val("rb_state_run", 32'(dut.state_reg), 32'd0);
    check_val("rb_stall_d", 32'(hz.stall_d), 32'd0);
`ifdef IDEX_HAZARD_STATS_EN
    check_val("rb_stall_cnt", stall_cnt, 32'd0);
    check_val("rb_flush_cnt", flush_cnt, 32'd0);
`endif
    reset = 1'b0;

    // Undefined SrcB code passes through and masks forward_b
    drive_d(3'b111, 1'b0, 2'b00, 5'd0, 5'd7, 5'd0);
    step();
    drive_mw(1'b1, 5'd7, 1'b0, 5'd0);
    #1;
    check_val("undef_alu_src_b_e", 32'(hz.alu_src_b_e), 32'd7);
    check_val("undef_fwd_b", 32'(hz.forward_b_e), 32'd0);
    check_val("undef_fwd_wd", 32'(hz.forward_wd_e), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/idex_hazard_ctrl.md
IDEX_HAZARD_CTRL -- requirements
Module: idex_hazard_ctrl

Interface
REQ-001 SHALL have: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: alu_src_b_d  in  3  decode SrcB select; 000 reg, 010 imm, 100 const 4, 110 const 12.
REQ-004 SHALL have: reg_write_d in 1; result_src_d in 2 (01 = load); rs1_d, rs2_d, rd_d in 5 each (decode fields).
REQ-005 SHALL have: rd_m, rd_w in 5; reg_write_m, reg_write_w in 1 (Memory/Writeback destination info).
REQ-006 SHALL have: pc_src_e  in  1  taken branch/jump resolved in Execute.
REQ-007 SHALL have: alu_src_b_e out 3; reg_write_e out 1; result_src_e out 2; rs1_e, rs2_e, rd_e out 5 (registered Execute controls).
REQ-008 SHALL have: forward_a_e, forward_b_e, forward_wd_e  out  2  forward selects: 00 regfile, 01 Writeback, 10 Memory.
REQ-009 SHALL have: stall_f, stall_d, flush_d, flush_e  out  1  pipeline control.

Function
REQ-010 SHALL register all REQ-007 outputs on rising clk: flush_e=1 loads bubble (alu_src_b_e=000, reg_write_e=0, result_src_e=00, rs1_e=rs2_e=rd_e=0); else captures *_d inputs; latency 1 cycle.
REQ-011 SHALL compute load-use hazard lu = (result_src_e==01) and rd_e!=0 and (rd_e==rs1_d or rd_e==rs2_d).
REQ-012 SHALL keep a 2-state FSM: RUN, BUBBLE; RUN->BUBBLE when lu=1 and pc_src_e=0; BUBBLE->RUN unconditionally next cycle; pc_src_e=1 forces next state RUN.
REQ-013 SHALL drive stall_f=stall_d=lu and not pc_src_e (combinational, same cycle).
REQ-014 SHALL drive flush_d=pc_src_e; flush_e=pc_src_e or lu.
REQ-015 SHALL, in BUBBLE, guarantee lu=0 (Execute holds bubble); assertion of lu in BUBBLE is an error flagged in verification.
REQ-016 SHALL drive forward_a_e: 10 if reg_write_m, rd_m!=0, rd_m==rs1_e; else 01 if reg_write_w, rd_w!=0, rd_w==rs1_e; else 00 (Memory priority over Writeback).
REQ-017 SHALL drive forward_wd_e by REQ-016 rule using rs2_e, unmasked (store write data).
REQ-018 SHALL drive forward_b_e = forward_wd_e when alu_src_b_e==000, else 00 (SrcB mux not selecting register).
REQ-019 SHALL treat x0 (register 0) as never hazarding or forwarding.
REQ-020 SHALL give pc_src_e priority over lu when both asserted: no stall, both flushes asserted.
REQ-021 SHALL pass any alu_src_b_d value unmodified, including undefined codes.

Reset
REQ-022 SHALL on reset=1 at clk edge load bubble values of REQ-010 into all E registers and set FSM to RUN, overriding flush and capture.
REQ-023 SHALL, in first cycle after reset with pc_src_e=0, output stall_f=stall_d=flush_d=flush_e=0 and all forward selects 00.
REQ-024 SHALL make reset mid-BUBBLE return to RUN with no residual stall.

Configuration
REQ-025 SHALL compile 32-bit counters stall_cnt and flush_cnt (outputs, out 32) only when macro IDEX_HAZARD_STATS_EN is defined.
REQ-026 SHALL, with IDEX_HAZARD_STATS_EN, increment stall_cnt each cycle stall_d=1 and flush_cnt each cycle flush_d=1, wrap 0xFFFFFFFF->0, clear on reset.
REQ-027 SHALL, without IDEX_HAZARD_STATS_EN, omit both ports and counters; all other behaviour identical.

Verification
REQ-028 Load-use: E holds lw rd_e=5 (result_src_e=01); D rs1_d=5 -> stall_f=stall_d=flush_e=1 one cycle, next cycle alu_src_b_e=000, reg_write_e=0, stall deasserted.
REQ-029 Forward priority: rs1_e=3, rd_m=3, rd_w=3, both reg_write=1 -> forward_a_e=10; reg_write_m=0 -> 01.
REQ-030 SrcB masking: rs2_e=7, rd_m=7, reg_write_m=1, alu_src_b_e=010 -> forward_b_e=00, forward_wd_e=10; alu_src_b_e=000 -> forward_b_e=10.
REQ-031 Branch vs load-use: lu condition plus pc_src_e=1 -> stall_f=stall_d=0, flush_d=flush_e=1, FSM stays RUN.
REQ-032 x0: rd_e=0 load, rs1_d=0 -> no stall; rd_m=0, rs1_e=0 -> forward_a_e=00.
REQ-033 Reset mid-BUBBLE with alu_src_b_d=110 -> next cycle alu_src_b_e=000, FSM RUN; with IDEX_HAZARD_STATS_EN stall_cnt=0.
